// File: rtl/shl_insert_unit_if.sv
// Request/response bundle for the shift-insert unit.
// The controller side (master) issues requests; the shifter side (slave) answers.
interface shl_insert_unit_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
);

  logic             start;
  logic [WIDTH-1:0] din;
  logic [SHW-1:0]   shamt;
  logic             fill;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;
  logic             cout;

  modport master (
    output start, din, shamt, fill,
    input  busy, done, dout, cout
  );

  modport slave (
    input  start, din, shamt, fill,
    output busy, done, dout, cout
  );

endinterface

// File: rtl/shl_insert_unit.sv
// Multi-cycle logical left shifter with serial fill-bit insertion.
// Moves one bit toward the MSB per clock, feeding a latched fill bit in at
// the LSB. The result register only changes on the completion edge, so the
// previous result stays readable while a new request is being worked on.
module shl_insert_unit #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input logic              clk,
  input logic              rst_n,
  shl_insert_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SHW-1:0] CNT_ZERO = '0;
  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   cnt;
  logic             fill_q;
  logic [WIDTH-1:0] dout_q;
  logic             cout_q;

  logic             accept;
  logic             cnt_is_zero;
  logic             cnt_is_one;
  logic [WIDTH-1:0] shifted;

  // Request acceptance and the one-step shift candidate. SHIFT never accepts,
  // so a start pulse mid-operation has no effect at all.
  always_comb begin
    accept      = bus.start && (state != SHIFT);
    cnt_is_zero = (cnt == CNT_ZERO);
    cnt_is_one  = (cnt == CNT_ONE);
    shifted     = {work[WIDTH-2:0], fill_q};
  end

  // State register; reset drops any request in flight without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Every request passes through SHIFT, even a zero shift,
  // so completion is always at least one edge after acceptance. DONE accepts
  // a new start directly, which gives back-to-back operation with no bubble.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = SHIFT;
      end
      SHIFT: begin
        if (cnt_is_zero || cnt_is_one) state_next = DONE;
      end
      DONE: begin
        if (accept) state_next = SHIFT;
        else        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Working datapath: load the operand on accept, then shift once per edge
  // while there is still a count to consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work   <= '0;
      cnt    <= '0;
      fill_q <= 1'b0;
    end else if (accept) begin
      work   <= bus.din;
      cnt    <= bus.shamt;
      fill_q <= bus.fill;
    end else if (state == SHIFT && !cnt_is_zero) begin
      work <= shifted;
      cnt  <= cnt - CNT_ONE;
    end
  end

  // Result commit on the completion edge only. A zero count commits the
  // operand unchanged with no carry; the last real shift commits the shifted
  // word and the bit that fell off the MSB on that shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      cout_q <= 1'b0;
    end else if (state == SHIFT) begin
      if (cnt_is_zero) begin
        dout_q <= work;
        cout_q <= 1'b0;
      end else if (cnt_is_one) begin
        dout_q <= shifted;
        cout_q <= work[WIDTH-1];
      end
    end
  end

  // Handshake outputs decode directly from the state register.
  always_comb begin
    bus.busy = (state == SHIFT);
    bus.done = (state == DONE);
    bus.dout = dout_q;
    bus.cout = cout_q;
  end

`ifndef SYNTHESIS
  // The completion pulse never lasts more than one cycle.
  done_single_cycle: assert property (
    @(posedge clk) disable iff (!rst_n) (state == DONE) |=> (state != DONE)
  );
`endif

endmodule
